// File: rtl/init_loader_pkg.sv
// Shared types and sizing helpers for the serial init-word loader.
package init_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        LOAD
    } init_state_t;

    function automatic int calcChunks(input int size, input int chunk);
        return size / chunk;
    endfunction

    // One extra count value so the counter can hold N after the final chunk.
    function automatic int calcCntWidth(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/init_loader_chunk_shifter.sv
// MSB-first shift register that packs CHUNK-wide slices into a SIZE-bit word.
module chunk_shifter #(
    parameter int SIZE  = 4,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic [CHUNK-1:0] i_din,
    output logic [SIZE-1:0]  o_q
);

    logic [SIZE-1:0] r_shreg;

    generate
        if (CHUNK == SIZE) begin : g_whole
            // A single chunk fills the word, so there is nothing to shift out.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_shreg <= '0;
                end else if (i_clr) begin
                    r_shreg <= '0;
                end else if (i_shift) begin
                    r_shreg <= i_din;
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_shreg <= '0;
                end else if (i_clr) begin
                    r_shreg <= '0;
                end else if (i_shift) begin
                    r_shreg <= {r_shreg[SIZE-CHUNK-1:0], i_din};
                end
            end
        end
    endgenerate

    assign o_q = r_shreg;

endmodule

// File: rtl/init_loader.sv
// Collects SIZE/CHUNK chunks over valid/ready after a start command, then
// strobes the assembled word into the downstream init register for one cycle.
module init_loader
    import init_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_in_valid,
    input  logic [CHUNK-1:0] i_in_data,
    output logic             o_in_ready,
    output logic [SIZE-1:0]  o_val,
    output logic             o_en,
    output logic             o_busy
);

    localparam int N     = calcChunks(SIZE, CHUNK);
    localparam int CNT_W = calcCntWidth(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    generate
        if ((SIZE % CHUNK) != 0) begin : g_bad_chunk
            $error("init_loader: SIZE must be a multiple of CHUNK");
        end
    endgenerate

    init_state_t      r_state;
    init_state_t      w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_clr;

    assign w_accept = (r_state == COLLECT) && i_in_valid;
    assign w_clr    = (r_state == IDLE) && i_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_clr) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = COLLECT;
                end
            end
            COLLECT: begin
                if (w_accept && (r_cnt == LAST_CNT)) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Outputs decode only the registered state, keeping inputs off every output path.
    assign o_in_ready = (r_state == COLLECT);
    assign o_en       = (r_state == LOAD);
    assign o_busy     = (r_state != IDLE);

    chunk_shifter #(
        .SIZE  (SIZE),
        .CHUNK (CHUNK)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_shift (w_accept),
        .i_din   (i_in_data),
        .o_q     (o_val)
    );

endmodule

// File: tb/tb_init_loader.sv
// Directed bench for init_loader at SIZE/CHUNK = 4/1, 8/2 and 4/4, each
// feeding a modelled downstream enable-loaded register.
module tb_init_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       aStart = 1'b0;
    logic       aValid = 1'b0;
    logic [0:0] aData  = '0;
    logic       aReady, aEn, aBusy;
    logic [3:0] aVal;
    logic [3:0] aDown;

    logic       bStart = 1'b0;
    logic       bValid = 1'b0;
    logic [1:0] bData  = '0;
    logic       bReady, bEn, bBusy;
    logic [7:0] bVal;
    logic [7:0] bDown;

    logic       cStart = 1'b0;
    logic       cValid = 1'b0;
    logic [3:0] cData  = '0;
    logic       cReady, cEn, cBusy;
    logic [3:0] cVal;
    logic [3:0] cDown;

    int checks    = 0;
    int passed    = 0;
    int failed    = 0;
    int aEnCount  = 0;
    int bEnCount  = 0;
    int cEnCount  = 0;

    init_loader #(.SIZE(4), .CHUNK(1)) dutA (
        .clk(clk), .rst(rst), .i_start(aStart), .i_in_valid(aValid),
        .i_in_data(aData), .o_in_ready(aReady), .o_val(aVal), .o_en(aEn), .o_busy(aBusy)
    );

    init_loader #(.SIZE(8), .CHUNK(2)) dutB (
        .clk(clk), .rst(rst), .i_start(bStart), .i_in_valid(bValid),
        .i_in_data(bData), .o_in_ready(bReady), .o_val(bVal), .o_en(bEn), .o_busy(bBusy)
    );

    init_loader #(.SIZE(4), .CHUNK(4)) dutC (
        .clk(clk), .rst(rst), .i_start(cStart), .i_in_valid(cValid),
        .i_in_data(cData), .o_in_ready(cReady), .o_val(cVal), .o_en(cEn), .o_busy(cBusy)
    );

    always #5 clk = ~clk;

    // Downstream init registers: capture val on the edge that ends the en cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            aDown <= '0;
            bDown <= '0;
            cDown <= '0;
        end else begin
            if (aEn) aDown <= aVal;
            if (bEn) bDown <= bVal;
            if (cEn) cDown <= cVal;
        end
    end

    always @(negedge clk) begin
        if (aEn) aEnCount++;
        if (bEn) bEnCount++;
        if (cEn) cEnCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        tick();
        tick();
        checkOutput("rst_a_val",   32'(aVal),   32'h0);
        checkOutput("rst_a_en",    32'(aEn),    32'h0);
        checkOutput("rst_a_ready", 32'(aReady), 32'h0);
        checkOutput("rst_a_busy",  32'(aBusy),  32'h0);
        checkOutput("rst_b_val",   32'(bVal),   32'h0);
        checkOutput("rst_c_busy",  32'(cBusy),  32'h0);
        rst = 1'b0;
        tick();

        // 4/1: bits 1,0,1,1 -> 4'b1011, en in cycle 5
        aStart = 1'b1;
        tick();
        checkOutput("t1_ready_c1", 32'(aReady), 32'h1);
        checkOutput("t1_busy_c1",  32'(aBusy),  32'h1);
        aStart = 1'b0; aValid = 1'b1; aData = 1'b1;
        tick();
        checkOutput("t1_val_c2", 32'(aVal), 32'h1);
        aData = 1'b0;
        tick();
        checkOutput("t1_val_c3", 32'(aVal), 32'h2);
        aData = 1'b1;
        tick();
        checkOutput("t1_en_c4", 32'(aEn), 32'h0);
        tick();
        checkOutput("t1_en_c5",  32'(aEn),  32'h1);
        checkOutput("t1_val_c5", 32'(aVal), 32'hB);
        checkOutput("t1_ready_c5", 32'(aReady), 32'h0);
        aValid = 1'b0;
        tick();
        checkOutput("t1_en_c6",   32'(aEn),    32'h0);
        checkOutput("t1_busy_c6", 32'(aBusy),  32'h0);
        checkOutput("t1_down",    32'(aDown),  32'hB);
        checkOutput("t1_pulses",  32'(aEnCount), 32'h1);

        // 8/2: chunks 11,00,10,01 with valid gaps of 0,3,1 -> 8'hC9
        bStart = 1'b1;
        tick();
        bStart = 1'b0; bValid = 1'b1; bData = 2'b11;
        tick();
        bData = 2'b00;
        tick();
        checkOutput("t2_val_2chunks", 32'(bVal), 32'h0C);
        bValid = 1'b0; bData = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t2_val_gap3",   32'(bVal),   32'h0C);
            checkOutput("t2_ready_gap3", 32'(bReady), 32'h1);
        end
        bValid = 1'b1; bData = 2'b10;
        tick();
        checkOutput("t2_val_3chunks", 32'(bVal), 32'h32);
        bValid = 1'b0; bData = 2'b11;
        tick();
        checkOutput("t2_val_gap1", 32'(bVal), 32'h32);
        checkOutput("t2_en_gap1",  32'(bEn),  32'h0);
        bValid = 1'b1; bData = 2'b01;
        tick();
        checkOutput("t2_en_load",  32'(bEn),  32'h1);
        checkOutput("t2_val_load", 32'(bVal), 32'hC9);
        bValid = 1'b0;
        tick();
        checkOutput("t2_en_after", 32'(bEn),      32'h0);
        checkOutput("t2_busy",     32'(bBusy),    32'h0);
        checkOutput("t2_down",     32'(bDown),    32'hC9);
        checkOutput("t2_pulses",   32'(bEnCount), 32'h1);

        // 4/1: reset after two chunks, then a fresh 4'b0110
        aStart = 1'b1;
        tick();
        aStart = 1'b0; aValid = 1'b1; aData = 1'b1;
        tick();
        tick();
        checkOutput("t3_val_partial", 32'(aVal), 32'h3);
        aValid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t3_val_rst",   32'(aVal),   32'h0);
        checkOutput("t3_busy_rst",  32'(aBusy),  32'h0);
        checkOutput("t3_ready_rst", 32'(aReady), 32'h0);
        tick();
        checkOutput("t3_no_en", 32'(aEnCount), 32'h1);
        aStart = 1'b1;
        tick();
        aStart = 1'b0; aValid = 1'b1; aData = 1'b0;
        tick();
        aData = 1'b1;
        tick();
        tick();
        aData = 1'b0;
        tick();
        checkOutput("t3_en_load",  32'(aEn),  32'h1);
        checkOutput("t3_val_load", 32'(aVal), 32'h6);
        aValid = 1'b0;
        tick();
        checkOutput("t3_down",   32'(aDown),    32'h6);
        checkOutput("t3_pulses", 32'(aEnCount), 32'h2);

        // 4/1: start and valid held high; IDLE/LOAD must not consume chunks
        aStart = 1'b1; aValid = 1'b1; aData = 1'b1;
        tick();
        checkOutput("t4_val_noidle", 32'(aVal),   32'h0);
        checkOutput("t4_ready_c1",   32'(aReady), 32'h1);
        tick();
        tick();
        aData = 1'b0;
        tick();
        checkOutput("t4_busy_start_ignored", 32'(aBusy), 32'h1);
        tick();
        checkOutput("t4_en_load",  32'(aEn),  32'h1);
        checkOutput("t4_val_load", 32'(aVal), 32'hC);
        aData = 1'b1;
        tick();
        checkOutput("t4_val_idle",   32'(aVal),   32'hC);
        checkOutput("t4_ready_idle", 32'(aReady), 32'h0);
        checkOutput("t4_busy_idle",  32'(aBusy),  32'h0);
        checkOutput("t4_pulses",     32'(aEnCount), 32'h3);
        tick();
        checkOutput("t4_restart_val",   32'(aVal),   32'h0);
        checkOutput("t4_restart_ready", 32'(aReady), 32'h1);
        aStart = 1'b0; aValid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // 4/4: a single chunk goes straight to LOAD
        cStart = 1'b1;
        tick();
        cStart = 1'b0; cValid = 1'b1; cData = 4'h9;
        checkOutput("t5_ready_c1", 32'(cReady), 32'h1);
        checkOutput("t5_en_c1",    32'(cEn),    32'h0);
        tick();
        checkOutput("t5_en_load",  32'(cEn),  32'h1);
        checkOutput("t5_val_load", 32'(cVal), 32'h9);
        cValid = 1'b0;
        tick();
        checkOutput("t5_en_after", 32'(cEn),      32'h0);
        checkOutput("t5_busy",     32'(cBusy),    32'h0);
        checkOutput("t5_down",     32'(cDown),    32'h9);
        checkOutput("t5_pulses",   32'(cEnCount), 32'h1);

        // 4/1: back-to-back 4'hA then 4'h5, second start on first IDLE cycle
        aStart = 1'b1;
        tick();
        aStart = 1'b0; aValid = 1'b1; aData = 1'b1;
        tick();
        aData = 1'b0;
        tick();
        aData = 1'b1;
        tick();
        aData = 1'b0;
        tick();
        checkOutput("t6_en_first",  32'(aEn),  32'h1);
        checkOutput("t6_val_first", 32'(aVal), 32'hA);
        aValid = 1'b0; aStart = 1'b1;
        tick();
        checkOutput("t6_en_gap",   32'(aEn),   32'h0);
        checkOutput("t6_busy_gap", 32'(aBusy), 32'h0);
        checkOutput("t6_down_a",   32'(aDown), 32'hA);
        tick();
        aStart = 1'b0; aValid = 1'b1; aData = 1'b0;
        tick();
        aData = 1'b1;
        tick();
        aData = 1'b0;
        tick();
        aData = 1'b1;
        checkOutput("t6_en_before", 32'(aEn), 32'h0);
        tick();
        checkOutput("t6_en_second",  32'(aEn),  32'h1);
        checkOutput("t6_val_second", 32'(aVal), 32'h5);
        aValid = 1'b0;
        tick();
        checkOutput("t6_down_5",  32'(aDown),    32'h5);
        checkOutput("t6_pulses",  32'(aEnCount), 32'h5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
